// File: rtl/log_capture_mem_if.sv
// Bus between the micro command decoder / receiver datapath and the capture buffer.
// The decoder side drives the i_* controls and samples; the buffer drives the o_* status and read data.
interface log_capture_mem_if #(
    parameter int NB_SAMP = 16,
    parameter int NB_ADDR = 15
);
    localparam int NB_WORD = 2 * NB_SAMP;

    logic               i_run;
    logic               i_read;
    logic [NB_ADDR-1:0] i_addr;
    logic               i_valid;
    logic [NB_SAMP-1:0] i_samp_I;
    logic [NB_SAMP-1:0] i_samp_Q;
    logic               o_full;
    logic               o_busy;
    logic [NB_WORD-1:0] o_data;
    logic [NB_ADDR:0]   o_wr_count;

    modport master (
        output i_run, i_read, i_addr, i_valid, i_samp_I, i_samp_Q,
        input  o_full, o_busy, o_data, o_wr_count
    );

    modport slave (
        input  i_run, i_read, i_addr, i_valid, i_samp_I, i_samp_Q,
        output o_full, o_busy, o_data, o_wr_count
    );
endinterface

// File: rtl/log_capture_mem.sv
// Capture buffer: on a run pulse it records DEPTH consecutive {I,Q} sample pairs,
// raises o_full when complete and then serves registered random-access reads.
module log_capture_mem #(
    parameter int NB_SAMP = 16,
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 15,
    parameter int DEPTH   = 32768
) (
    input  logic               clock,
    input  logic               reset,
    log_capture_mem_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_PTR = NB_ADDR'(DEPTH - 1);
    localparam logic [NB_ADDR-1:0] PTR_ONE  = NB_ADDR'(1);
    localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR:0]   wr_count_q, wr_count_d;
    logic               full_q, full_d;
    logic               busy_q, busy_d;
    logic [NB_WORD-1:0] data_q;
    logic               wr_en;
    logic               rd_en;

    logic [NB_WORD-1:0] mem [DEPTH];

    // A run pulse takes priority over everything else in every state, so a
    // coincident sample is dropped and a coincident read leaves o_data alone.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        full_d     = full_q;
        busy_d     = busy_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        if (bus.i_run) begin
            state_d    = CAPTURE;
            wr_ptr_d   = '0;
            wr_count_d = '0;
            full_d     = 1'b0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (bus.i_valid) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        wr_count_d = wr_count_q + CNT_ONE;
                        if (wr_ptr_q == LAST_PTR) begin
                            state_d = FULL;
                            full_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                FULL: begin
                    rd_en = bus.i_read;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
        end
    end

    // Storage has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {bus.i_samp_I, bus.i_samp_Q};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem[bus.i_addr];
        end
    end

    assign bus.o_full     = full_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_data     = data_q;
    assign bus.o_wr_count = wr_count_q;

endmodule
